// File: rtl/sar_busca4.sv
// sar_busca4 -- successive-approximation search controller.
//
// Drives the B word of an external combinational magnitude comparator and
// binary-searches the unknown A word from the AmaiorB / AmenorB / AigualB
// flags. The search starts at the MSB and settles one bit per cycle. It can
// also finish early when the comparator reports equality.
//
// State table
//   state  | meaning
//   OCIOSO | idle; inicio starts a search, B keeps its last value
//   TESTE  | one decision per clock using the flags for the current B
//   FIM    | pronto pulse for one cycle, then back to OCIOSO
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   inicio     in   start request, honoured only in OCIOSO
//   AmaiorB    in   comparator flag A > B
//   AmenorB    in   comparator flag A < B
//   AigualB    in   comparator flag A = B
//   B          out  registered trial word to the comparator
//   ocupado    out  high while in TESTE
//   pronto     out  high while in FIM (one cycle)
//   erro       out  flags were not one-hot; held until next accepted inicio
//   resultado  out  found A value; held until the next completion
module sar_busca4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic             AmaiorB,
  input  logic             AmenorB,
  input  logic             AigualB,
  output logic [WIDTH-1:0] B,
  output logic             ocupado,
  output logic             pronto,
  output logic             erro,
  output logic [WIDTH-1:0] resultado
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    TESTE  = 2'd1,
    FIM    = 2'd2
  } stateT;

  localparam logic [WIDTH-1:0] msbOne = {1'b1, {(WIDTH-1){1'b0}}};

  stateT            state;
  stateT            stateNext;
  // Bit pointer kept one-hot so that stepping to the next bit and clearing
  // the tested bit are pure shifts/masks; no decrementer is needed.
  logic [WIDTH-1:0] idx;
  logic [WIDTH-1:0] idxNext;
  logic [WIDTH-1:0] bNext;
  logic [WIDTH-1:0] resultadoNext;
  logic             erroNext;
  logic [2:0]       flags;
  logic             flagsOk;
  logic [WIDTH-1:0] trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OCIOSO;
      B         <= '0;
      idx       <= '0;
      resultado <= '0;
      erro      <= 1'b0;
    end else begin
      state     <= stateNext;
      B         <= bNext;
      idx       <= idxNext;
      resultado <= resultadoNext;
      erro      <= erroNext;
    end
  end

  assign flags   = {AmaiorB, AmenorB, AigualB};
  assign flagsOk = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  // Tested bit is dropped when A < B, kept when A > B.
  assign trial   = AmenorB ? (B & ~idx) : B;

  always_comb begin
    stateNext     = state;
    bNext         = B;
    idxNext       = idx;
    resultadoNext = resultado;
    erroNext      = erro;
    case (state)
      OCIOSO: begin
        if (inicio) begin
          bNext     = msbOne;
          idxNext   = msbOne;
          erroNext  = 1'b0;
          stateNext = TESTE;
        end
      end
      TESTE: begin
        if (!flagsOk) begin
          resultadoNext = '0;
          erroNext      = 1'b1;
          stateNext     = FIM;
        end else if (AigualB) begin
          resultadoNext = B;
          stateNext     = FIM;
        end else if (idx[0]) begin
          resultadoNext = trial;
          bNext         = trial;
          stateNext     = FIM;
        end else begin
          bNext   = trial | (idx >> 1);
          idxNext = idx >> 1;
        end
      end
      FIM: begin
        stateNext = OCIOSO;
      end
      default: begin
        stateNext = OCIOSO;
      end
    endcase
  end

  always_comb begin
    ocupado = (state == TESTE);
    pronto  = (state == FIM);
  end

endmodule

// File: tb/tb_sar_busca4.sv
// Bench for sar_busca4 with a behavioural comparator on the B side and an
// override path for injecting illegal flag combinations.
module tb_sar_busca4;

  logic       clk;
  logic       rst_n;
  logic       inicio;
  logic [3:0] aVal;
  logic       ovr;
  logic [2:0] ovrFlags;
  logic       AmaiorB;
  logic       AmenorB;
  logic       AigualB;
  logic [3:0] B;
  logic       ocupado;
  logic       pronto;
  logic       erro;
  logic [3:0] resultado;

  int checks = 0;
  int errors = 0;
  int bLog[0:9];

  sar_busca4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inicio    (inicio),
    .AmaiorB   (AmaiorB),
    .AmenorB   (AmenorB),
    .AigualB   (AigualB),
    .B         (B),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .erro      (erro),
    .resultado (resultado)
  );

  assign AmaiorB = ovr ? ovrFlags[2] : (aVal > B);
  assign AmenorB = ovr ? ovrFlags[1] : (aVal < B);
  assign AigualB = ovr ? ovrFlags[0] : (aVal == B);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decisions needed: equality is hit when the trial reaches A's lowest set
  // bit; A=0 walks every bit.
  function automatic int expK(input logic [3:0] a);
    for (int i = 0; i < 4; i++)
      if (a[i]) return 4 - i;
    return 4;
  endfunction

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_B"}, 32'(B), 0);
    checkVal({tag, "_ocupado"}, 32'(ocupado), 0);
    checkVal({tag, "_pronto"}, 32'(pronto), 0);
    checkVal({tag, "_erro"}, 32'(erro), 0);
    checkVal({tag, "_resultado"}, 32'(resultado), 0);
  endtask

  task automatic doSearch(input logic [3:0] a, input int k);
    int n;
    int occ;
    aVal   = a;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    bLog[0] = 32'(B);
    checkVal("b_start", 32'(B), 8);
    checkVal("ocupado_start", 32'(ocupado), 1);
    n = 0;
    occ = 1;
    while (!pronto && n < 8) begin
      tick();
      n++;
      bLog[n] = 32'(B);
      if (ocupado) occ++;
    end
    checkVal("latency", n, k);
    checkVal("ocupado_cycles", occ, k);
    checkVal("resultado", 32'(resultado), 32'(a));
    checkVal("erro", 32'(erro), 0);
    tick();
    checkVal("pronto_once", 32'(pronto), 0);
    checkVal("idle_ocupado", 32'(ocupado), 0);
    checkVal("resultado_held", 32'(resultado), 32'(a));
  endtask

  initial begin
    rst_n    = 1'b0;
    inicio   = 1'b0;
    aVal     = 4'd0;
    ovr      = 1'b0;
    ovrFlags = 3'b000;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkAllZero("post_reset");

    // Reset mid-search: A=5, abort after the 2nd decision.
    aVal   = 4'd5;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick();
    tick();
    checkVal("pre_abort_B", 32'(B), 6);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    doSearch(4'd5, 4);

    // Early exit on the first trial.
    doSearch(4'd8, 1);

    // Directed sequences.
    doSearch(4'd5, 4);
    checkVal("seq5_b1", bLog[1], 4);
    checkVal("seq5_b2", bLog[2], 6);
    checkVal("seq5_b3", bLog[3], 5);
    doSearch(4'd0, 4);
    checkVal("seq0_b1", bLog[1], 4);
    checkVal("seq0_b2", bLog[2], 2);
    checkVal("seq0_b3", bLog[3], 1);
    checkVal("seq0_b4", bLog[4], 0);
    doSearch(4'd15, 4);
    checkVal("seq15_b3", bLog[3], 15);

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++)
      doSearch(4'(a), expK(4'(a)));

    // Illegal flags during the 2nd test.
    aVal   = 4'd5;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick();
    ovr      = 1'b1;
    ovrFlags = 3'b110;
    tick();
    ovr = 1'b0;
    checkVal("bad_pronto", 32'(pronto), 1);
    checkVal("bad_erro", 32'(erro), 1);
    checkVal("bad_resultado", 32'(resultado), 0);
    tick();
    checkVal("bad_erro_held", 32'(erro), 1);
    checkVal("bad_pronto_drop", 32'(pronto), 0);
    doSearch(4'd5, 4);

    // inicio held high: no restart during TESTE/FIM, one idle cycle between runs.
    aVal   = 4'd3;
    inicio = 1'b1;
    tick();
    checkVal("hold_b0", 32'(B), 8);
    tick();
    checkVal("hold_b1", 32'(B), 4);
    tick();
    checkVal("hold_b2", 32'(B), 2);
    tick();
    checkVal("hold_b3", 32'(B), 3);
    tick();
    checkVal("hold_pronto", 32'(pronto), 1);
    checkVal("hold_resultado", 32'(resultado), 3);
    checkVal("hold_fim_B", 32'(B), 3);
    tick();
    checkVal("hold_idle_ocupado", 32'(ocupado), 0);
    checkVal("hold_idle_pronto", 32'(pronto), 0);
    checkVal("hold_idle_B", 32'(B), 3);
    tick();
    checkVal("hold_restart_ocupado", 32'(ocupado), 1);
    checkVal("hold_restart_B", 32'(B), 8);
    inicio = 1'b0;
    for (int i = 0; i < 8 && !pronto; i++) tick();
    checkVal("hold_second_pronto", 32'(pronto), 1);
    checkVal("hold_second_resultado", 32'(resultado), 3);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_busca4.md
# sar_busca4

Successive-approximation search controller that drives the B word of the 4-bit magnitude comparator and consumes its AmaiorB/AmenorB/AigualB flags. It binary-searches the unknown A word presented to the comparator and returns A as a registered result. The block sits on the opposite side of the comparator interface from the comparator itself: it generates B and interprets the flags. The flag path from B back to this block is purely combinational, within one clock cycle.

## Interface

- WIDTH, 4, word width of A/B/resultado; legal range ≥ 2

Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n).

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- inicio  input  1  start request; sampled only in OCIOSO
- AmaiorB  input  1  comparator flag, A > B
- AmenorB  input  1  comparator flag, A < B
- AigualB  input  1  comparator flag, A = B
- B  output  WIDTH  registered trial word driven to the comparator
- ocupado  output  1  high while a search is in progress (TESTE state)
- pronto  output  1  one-cycle pulse, search finished (FIM state)
- erro  output  1  flags were not one-hot during the search; valid with pronto and held until next accepted inicio
- resultado  output  WIDTH  found A value; held until the next completion

## Operation

- States: OCIOSO, TESTE, FIM. Registers: B, idx (bit pointer), resultado, erro.
- OCIOSO:
  - inicio=1 → B ← 1<<(WIDTH-1), idx ← WIDTH-1, erro ← 0, go to TESTE.
  - inicio=0 → stay; B holds its last value.
- TESTE: decision on each rising edge, using the flags for the current B.
  - Flags not exactly one-hot (none or several high): resultado ← 0, erro ← 1, go to FIM.
  - AigualB: resultado ← B, go to FIM (early exit).
  - Otherwise, let v = B with bit idx cleared if AmenorB, or kept if AmaiorB.
  - If idx = 0: resultado ← v, B ← v, go to FIM.
  - Else: B ← v | 1<<(idx-1), idx ← idx-1, stay in TESTE.
- FIM: pronto = 1 for exactly one cycle, then go to OCIOSO unconditionally. inicio is ignored in FIM and TESTE; it is not queued.
- Outputs decode from state:
  - ocupado = (state == TESTE)
  - pronto = (state == FIM)
- Arithmetic is bitwise only; no adders. B never exceeds 2^WIDTH-1.
- Reset (any time, including mid-search): state OCIOSO; B, resultado and idx all 0; erro, pronto and ocupado 0. Takes effect immediately (asynchronous); the search is abandoned.

## Timing

- inicio sampled at edge E0 → B = 100…0 and ocupado = 1 from E0.
- The k-th decision is made at edge Ek, with 1 ≤ k ≤ WIDTH.
- pronto is high for the cycle between E(k) and E(k+1).
- resultado and erro become valid at E(k), coincident with pronto rising.
- Latency from inicio edge to pronto: k+0 edges, i.e. 1 to WIDTH cycles. Worst case is WIDTH=4 → 4 cycles. The next inicio is accepted at E(k+2) at the earliest.
- The comparator is combinational, so flags must settle within the cycle that follows each B update. There is no extra pipeline stage.

## Test plan

- Reset mid-search: after rst_n deassert, all outputs are 0. Start a search with A=5; assert rst_n=0 after the 2nd decision → all outputs 0 asynchronously, state OCIOSO, and a subsequent search with A=5 completes correctly.
- Early exit: A=8, pulse inicio → B=1000, AigualB at E1 → pronto at E1, resultado=8, erro=0, 1-cycle latency.
- Full search sequences:
  - A=5: B goes 1000, 0100, 0110, 0101 → resultado=5 at E4.
  - A=0: B goes 1000, 0100, 0010, 0001 → resultado=0 via the idx=0 path at E4.
  - A=15: resultado=15 at E4.
- Exhaustive sweep: A=0..15, each connected to a real comparator → resultado=A for every value; pronto pulses exactly once per search; ocupado is high for exactly k cycles per search.
- Illegal flags: force AmaiorB=AmenorB=1 during the 2nd test → pronto at E2, erro=1, resultado=0. The next inicio with legal flags clears erro to 0.
- inicio held high continuously with A=3: a new search starts only from OCIOSO. No inicio pulse during TESTE or FIM alters B or restarts the search, and each pronto is followed by exactly one idle cycle.
